// File: rtl/persp_warp_mapper.sv
// persp_warp_mapper
//
// Maps a destination pixel (x, y) to a source pixel (u, v) through a
// projective transform held as eight signed fixed-point coefficients:
//   W = G*x + H*y + 2^FRAC_BITS
//   u = (A*x + B*y + C) / W
//   v = (D*x + E*y + F) / W
// Each request runs a fixed pipeline: multiply, sum, a 10-step restoring
// divide (u and v share the divisor), then a result-hold state.
//
// Handshake: a request is taken on a rising edge where i_req_valid and
// o_req_ready are both high; a result is taken on a rising edge where
// o_valid and i_rsp_ready are both high. o_valid/o_src_addr/o_oob stay
// stable until taken.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_coef_valid, A..H  coefficient load strobe and 33-bit signed coefficients
//   i_req_valid         pixel request, i_dst_addr = {x[19:10], y[9:0]}
//   o_req_ready         high only while waiting for a request
//   o_valid             result valid, i_rsp_ready accepts it
//   o_src_addr          {u[19:10], v[9:0]}
//   o_oob               source point lies outside the image
//   o_coef_ok           coefficients have been loaded since reset
//
// Build option: PERSP_WARP_CLAMP_EN -- when defined, out-of-bounds results
// carry u, v clamped into the image; otherwise they carry address 0.

module persp_warp_mapper #(
    parameter int FRAC_BITS = 16,
    parameter int IMG_W     = 800,
    parameter int IMG_H     = 600
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_coef_valid,
    input  logic signed [32:0] A,
    input  logic signed [32:0] B,
    input  logic signed [32:0] C,
    input  logic signed [32:0] D,
    input  logic signed [32:0] E,
    input  logic signed [32:0] F,
    input  logic signed [32:0] G,
    input  logic signed [32:0] H,
    input  logic               i_req_valid,
    input  logic [19:0]        i_dst_addr,
    output logic               o_req_ready,
    output logic               o_valid,
    input  logic               i_rsp_ready,
    output logic [19:0]        o_src_addr,
    output logic               o_oob,
    output logic               o_coef_ok
);
    typedef enum logic [2:0] {IDLE, READY, MUL, SUM, DIV, OUT} state_t;

    localparam logic signed [45:0] W_ONE    = 46'sd1 <<< FRAC_BITS;
    localparam logic [10:0]        IMG_W_L  = 11'(IMG_W);
    localparam logic [10:0]        IMG_H_L  = 11'(IMG_H);
    localparam logic [9:0]         U_MAX    = 10'(IMG_W - 1);
    localparam logic [9:0]         V_MAX    = 10'(IMG_H - 1);
    // Counts 0..9 are divide steps; count 10 formats the result.
    localparam logic [3:0]         DIV_LAST = 4'd10;

    state_t             state_q, state_d;
    logic signed [32:0] coef_in [8];
    logic signed [32:0] coef_q  [8];
    logic signed [32:0] pend_q  [8];
    logic               pend_valid_q;
    logic               coef_ok_q;
    logic [9:0]         x_q, y_q;
    logic signed [43:0] prod_d [6];
    logic signed [43:0] prod_q [6];   // A*x, B*y, D*x, E*y, G*x, H*y
    logic signed [45:0] sum_u, sum_v, sum_w;
    logic signed [55:0] w_lim;
    logic               w_bad_q, u_neg_q, u_ovf_q, v_neg_q, v_ovf_q;
    logic [55:0]        rem_u_q, rem_v_q, dvs_q;
    logic [9:0]         quo_u_q, quo_v_q;
    logic [3:0]         cnt_q;
    logic               ge_u, ge_v, u_big, v_big;
    logic [9:0]         fin_u, fin_v;
    logic               fin_oob;
    logic [19:0]        src_q;
    logic               oob_q;
    logic               leave_out, coef_direct;
    logic signed [10:0] xs, ys;

    always_comb begin
        coef_in[0] = A; coef_in[1] = B; coef_in[2] = C; coef_in[3] = D;
        coef_in[4] = E; coef_in[5] = F; coef_in[6] = G; coef_in[7] = H;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_valid     = 1'b0;
        case (state_q)
            IDLE:  if (i_coef_valid) state_d = READY;
            READY: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_d = MUL;
            end
            MUL:   state_d = SUM;
            SUM:   state_d = DIV;
            DIV:   if (cnt_q == DIV_LAST) state_d = OUT;
            OUT: begin
                o_valid = 1'b1;
                if (i_rsp_ready) state_d = READY;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath (combinational) ----------------
    assign leave_out = (state_q == OUT) && i_rsp_ready;
    // Strobes land directly whenever the FSM is (or is about to be) back in
    // READY; otherwise they are parked so the in-flight pixel is unaffected.
    assign coef_direct = i_coef_valid &&
                         (state_q == IDLE || state_q == READY || leave_out);

    assign xs = $signed({1'b0, x_q});
    assign ys = $signed({1'b0, y_q});

    always_comb begin
        prod_d[0] = 44'(coef_q[0]) * 44'(xs);
        prod_d[1] = 44'(coef_q[1]) * 44'(ys);
        prod_d[2] = 44'(coef_q[3]) * 44'(xs);
        prod_d[3] = 44'(coef_q[4]) * 44'(ys);
        prod_d[4] = 44'(coef_q[6]) * 44'(xs);
        prod_d[5] = 44'(coef_q[7]) * 44'(ys);
    end

    assign sum_u = 46'(prod_q[0]) + 46'(prod_q[1]) + 46'(coef_q[2]);
    assign sum_v = 46'(prod_q[2]) + 46'(prod_q[3]) + 46'(coef_q[5]);
    assign sum_w = 46'(prod_q[4]) + 46'(prod_q[5]) + W_ONE;
    // Quotient fits in 10 bits only when numerator < W * 1024.
    assign w_lim = 56'(sum_w) <<< 10;

    assign ge_u  = rem_u_q >= dvs_q;
    assign ge_v  = rem_v_q >= dvs_q;
    assign u_big = {1'b0, quo_u_q} >= IMG_W_L;
    assign v_big = {1'b0, quo_v_q} >= IMG_H_L;

    always_comb begin
        fin_oob = w_bad_q | u_neg_q | u_ovf_q | v_neg_q | v_ovf_q | u_big | v_big;
`ifdef PERSP_WARP_CLAMP_EN
        if (w_bad_q || u_neg_q)      fin_u = '0;
        else if (u_ovf_q || u_big)   fin_u = U_MAX;
        else                         fin_u = quo_u_q;
        if (w_bad_q || v_neg_q)      fin_v = '0;
        else if (v_ovf_q || v_big)   fin_v = V_MAX;
        else                         fin_v = quo_v_q;
`else
        fin_u = fin_oob ? '0 : quo_u_q;
        fin_v = fin_oob ? '0 : quo_v_q;
`endif
    end

    // ---------------- datapath (registers) ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                coef_q[i] <= '0;
                pend_q[i] <= '0;
            end
            for (int i = 0; i < 6; i++) prod_q[i] <= '0;
            pend_valid_q <= 1'b0;
            coef_ok_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            w_bad_q      <= 1'b0;
            u_neg_q      <= 1'b0;
            u_ovf_q      <= 1'b0;
            v_neg_q      <= 1'b0;
            v_ovf_q      <= 1'b0;
            rem_u_q      <= '0;
            rem_v_q      <= '0;
            dvs_q        <= '0;
            quo_u_q      <= '0;
            quo_v_q      <= '0;
            cnt_q        <= '0;
            src_q        <= '0;
            oob_q        <= 1'b0;
        end else begin
            if (coef_direct) begin
                coef_q       <= coef_in;
                pend_valid_q <= 1'b0;
                coef_ok_q    <= 1'b1;
            end else if (i_coef_valid) begin
                pend_q       <= coef_in;
                pend_valid_q <= 1'b1;
            end else if (leave_out && pend_valid_q) begin
                coef_q       <= pend_q;
                pend_valid_q <= 1'b0;
            end

            if (state_q == READY && i_req_valid) begin
                x_q <= i_dst_addr[19:10];
                y_q <= i_dst_addr[9:0];
            end

            if (state_q == MUL) prod_q <= prod_d;

            if (state_q == SUM) begin
                w_bad_q <= sum_w <= 46'sd0;
                u_neg_q <= sum_u < 46'sd0;
                v_neg_q <= sum_v < 46'sd0;
                u_ovf_q <= 56'(sum_u) >= w_lim;
                v_ovf_q <= 56'(sum_v) >= w_lim;
                rem_u_q <= {10'b0, sum_u};
                rem_v_q <= {10'b0, sum_v};
                dvs_q   <= {10'b0, sum_w} << 9;
                quo_u_q <= '0;
                quo_v_q <= '0;
                cnt_q   <= '0;
            end

            if (state_q == DIV) begin
                if (cnt_q != DIV_LAST) begin
                    if (ge_u) rem_u_q <= rem_u_q - dvs_q;
                    if (ge_v) rem_v_q <= rem_v_q - dvs_q;
                    quo_u_q <= {quo_u_q[8:0], ge_u};
                    quo_v_q <= {quo_v_q[8:0], ge_v};
                    dvs_q   <= dvs_q >> 1;
                    cnt_q   <= cnt_q + 4'd1;
                end else begin
                    src_q <= {fin_u, fin_v};
                    oob_q <= fin_oob;
                end
            end
        end
    end

    assign o_src_addr = src_q;
    assign o_oob      = oob_q;
    assign o_coef_ok  = coef_ok_q;

endmodule

// File: doc/persp_warp_mapper.md
PERSP_WARP_MAPPER -- requirements
Module: persp_warp_mapper

Interface
REQ-001 Parameters SHALL be: FRAC_BITS, 16, fractional bits of all coefficients; IMG_W, 800, source width in pixels; IMG_H, 600, source height in pixels.
REQ-002 Ports SHALL be: i_clk in 1 clock; i_rst in 1 synchronous active-high reset; i_coef_valid in 1 coefficient load strobe; A,B,C,D,E,F,G,H in 33 each signed fixed-point coefficients; i_req_valid in 1 pixel request; i_dst_addr in 20 {x[19:10],y[9:0]} destination pixel; o_req_ready out 1 request accept; o_valid out 1 result valid; i_rsp_ready in 1 result accept; o_src_addr out 20 {u,v} source pixel; o_oob out 1 out-of-bounds flag; o_coef_ok out 1 coefficients loaded.
REQ-003 Single clock i_clk; reset is synchronous and active-high on i_rst.

Function
REQ-004 Mapping SHALL be u = (A*x+B*y+C)/W, v = (D*x+E*y+F)/W, W = G*x+H*y+2^FRAC_BITS; x,y unsigned 10-bit, coefficients signed.
REQ-005 Products SHALL be 44-bit signed, sums 46-bit signed, no intermediate truncation.
REQ-006 Division SHALL be unsigned restoring, 10 quotient bits, u and v in parallel, truncation toward zero.
REQ-007 FSM states SHALL be IDLE, READY, MUL, SUM, DIV, OUT.
REQ-008 IDLE->READY on i_coef_valid; coefficients captured that edge; o_coef_ok=1 thereafter.
REQ-009 o_req_ready SHALL be 1 only in READY; request accepted on edge where i_req_valid&&o_req_ready (edge N).
REQ-010 MUL at N+1 registers six products; SUM at N+2 registers sums and oob checks; DIV iterates edges N+3..N+12; OUT with o_valid=1 from edge N+13.
REQ-011 o_oob SHALL be set if W<=0, either numerator <0, numerator >= W<<10, u>=IMG_W, or v>=IMG_H; divider still runs for fixed latency.
REQ-012 In OUT, o_valid, o_src_addr, o_oob SHALL hold stable until i_rsp_ready=1; OUT->READY on that edge.
REQ-013 i_rsp_ready already high on entry to OUT SHALL give a one-cycle o_valid pulse; next request accepted no earlier than following edge.
REQ-014 i_coef_valid outside IDLE/READY SHALL be held pending and applied on return to READY; in-flight pixel uses old coefficients; second strobe while pending overwrites pending values.
REQ-015 i_coef_valid and accepted request on same READY edge: request uses new coefficients.
REQ-016 Requests while o_req_ready=0 SHALL be ignored, not queued.

Reset
REQ-017 On i_rst: state IDLE, o_req_ready=0, o_valid=0, o_src_addr=0, o_oob=0, o_coef_ok=0, pending cleared, coefficients zeroed.
REQ-018 i_rst mid-MUL/SUM/DIV/OUT SHALL abort without emitting o_valid; i_rst overrides simultaneous i_coef_valid.

Configuration
REQ-019 Macro PERSP_WARP_CLAMP_EN: defined -> oob results output u,v clamped to [0,IMG_W-1],[0,IMG_H-1] (negative/W<=0 ->0, overflow ->max), o_oob still asserted; undefined -> oob results output o_src_addr=0.

Verification
REQ-020 A=E=65536, others 0, request (100,200) at edge N -> o_valid at N+13, o_src_addr={100,200}, o_oob=0.
REQ-021 A=E=65536, C=5*65536, request (10,10) -> {15,10}, o_oob=0.
REQ-022 A=E=65536, G=16384, request (4,8) -> W=2*65536, result {2,4}, o_oob=0.
REQ-023 A=E=65536, C=-50*65536, request (10,10) -> o_oob=1; {0,10} with PERSP_WARP_CLAMP_EN, {0,0} without; (900,10) identity -> o_oob=1, clamp {799,10}.
REQ-024 i_rsp_ready=0 for 5 cycles in OUT -> outputs stable, o_req_ready=0; i_coef_valid during DIV -> current result uses old coefficients, next uses new.
REQ-025 i_rst at N+6 -> no o_valid, all outputs reset next edge, o_coef_ok=0, requests ignored until new i_coef_valid.
